// File: rtl/memory_pkg.sv
// Shared types and constants for the multiport memory.
package memory_pkg;

   // Every lane of a write is one byte wide.
   localparam int LANE_W = 8;

   // The memory is either sweeping zeros after reset or serving traffic.
   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   // Number of address bits for a power-of-two depth.
   function automatic int addr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/memory_read_port.sv
// One read channel: ar/r handshake and the registered read-data output.
// The parent supplies rd_word, the (already forwarded) array word for ar_addr.
module memory_read_port
#(
   parameter int W = 16
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         ar_valid,
   output logic         ar_ready,
   input  logic [W-1:0] rd_word,
   output logic [W-1:0] r_data,
   output logic         r_valid,
   input  logic         r_ready
);

   logic fire;

   // A new address is taken whenever the output slot is empty or is being drained.
   assign ar_ready = en && (!r_valid || r_ready);
   assign fire     = ar_valid && ar_ready;

   // Output register: loads on an address handshake, otherwise holds until r_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (fire) begin
         r_valid <= 1'b1;
         r_data  <= rd_word;
      end else if (r_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/memory_multiport.sv
// Shared weight/activation memory: one strobed write channel with a response,
// N independent read channels, and an optional zero sweep after reset.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1. A source holds valid and its payload steady until that edge; ready
// never depends on the same channel's valid, except that aw_ready/w_ready each
// depend on the other write channel's valid so address and data move together.
module memory_multiport
#(
   parameter int W     = 16,
   parameter int D     = 256,
   parameter int N     = 2,
   parameter int CLEAR = 1
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [$clog2(D)-1:0]    aw_data,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [W-1:0]            w_data,
   input  logic [W/8-1:0]          w_strb,
   input  logic                    w_valid,
   output logic                    w_ready,
   output logic                    b_valid,
   input  logic                    b_ready,
   input  logic [N*$clog2(D)-1:0]  ar_data,
   input  logic [N-1:0]            ar_valid,
   output logic [N-1:0]            ar_ready,
   output logic [N*W-1:0]          r_data,
   output logic [N-1:0]            r_valid,
   input  logic [N-1:0]            r_ready
);

   import memory_pkg::*;

   localparam int A = addr_width(D);
   localparam int L = W / LANE_W;

   state_t       state;
   state_t       state_next;
   logic [A-1:0] ptr;
   logic [A-1:0] ptr_next;
   logic [W-1:0] mem [D];

   logic         run;
   logic         b_free;
   logic         accept;
   logic [W-1:0] wr_old;
   logic [W-1:0] wr_merged;

   // Traffic is only served in RUN and never while reset is held.
   assign run    = (state == memory_pkg::RUN) && !rst;

   // The response slot is free when empty or being drained this cycle.
   assign b_free   = !b_valid || b_ready;
   assign aw_ready = run && w_valid && b_free;
   assign w_ready  = run && aw_valid && b_free;
   assign accept   = run && aw_valid && w_valid && b_free;

   // State and sweep pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= (CLEAR != 0) ? memory_pkg::CLEAR : memory_pkg::RUN;
         ptr   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
      end
   end

   // Sweep one word per cycle; leave CLEAR after writing the last address.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      if (state == memory_pkg::CLEAR) begin
         ptr_next = ptr + A'(1);
         if (ptr == A'(D - 1)) begin
            state_next = memory_pkg::RUN;
         end
      end
   end

   assign wr_old = mem[aw_data];

   // Strobed lanes take new data; the rest keep the stored word.
   always_comb begin
      wr_merged = wr_old;
      for (int k = 0; k < L; k++) begin
         if (w_strb[k]) begin
            wr_merged[k*LANE_W +: LANE_W] = w_data[k*LANE_W +: LANE_W];
         end
      end
   end

   // Array write port: zero sweep in CLEAR, merged write on an accepted beat.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == memory_pkg::CLEAR) begin
            mem[ptr] <= '0;
         end else if (accept) begin
            mem[aw_data] <= wr_merged;
         end
      end
   end

   // Write response: raised after each accepted write, held until b_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_valid <= 1'b0;
      end else if (accept) begin
         b_valid <= 1'b1;
      end else if (b_ready) begin
         b_valid <= 1'b0;
      end
   end

   // Per-channel read with write-first forwarding of a same-cycle write.
   for (genvar i = 0; i < N; i++) begin : g_rd
      logic [A-1:0] addr;
      logic [W-1:0] rd_word;

      assign addr    = ar_data[i*A +: A];
      assign rd_word = (accept && (aw_data == addr)) ? wr_merged : mem[addr];

      memory_read_port #(.W(W)) u_rd (
         .clk      (clk),
         .rst      (rst),
         .en       (run),
         .ar_valid (ar_valid[i]),
         .ar_ready (ar_ready[i]),
         .rd_word  (rd_word),
         .r_data   (r_data[i*W +: W]),
         .r_valid  (r_valid[i]),
         .r_ready  (r_ready[i])
      );
   end

endmodule

// File: tb/tb_memory_multiport.sv
// Directed bench for memory_multiport: sweep, strobes, forwarding,
// backpressure, random fill/readback and mid-operation reset.
module tb_memory_multiport;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Main instance: W=16, D=256, N=2, CLEAR=1
   logic [7:0]  aw_data;
   logic        aw_valid, aw_ready;
   logic [15:0] w_data;
   logic [1:0]  w_strb;
   logic        w_valid, w_ready;
   logic        b_valid, b_ready;
   logic [15:0] ar_data;
   logic [1:0]  ar_valid, ar_ready;
   logic [31:0] r_data;
   logic [1:0]  r_valid, r_ready;

   // Second instance without the sweep: W=16, D=16, N=1, CLEAR=0
   logic        e_rst;
   logic [3:0]  e_aw_data;
   logic        e_aw_valid, e_aw_ready;
   logic [15:0] e_w_data;
   logic [1:0]  e_w_strb;
   logic        e_w_valid, e_w_ready;
   logic        e_b_valid, e_b_ready;
   logic [3:0]  e_ar_data;
   logic [0:0]  e_ar_valid, e_ar_ready;
   logic [15:0] e_r_data;
   logic [0:0]  e_r_valid, e_r_ready;

   memory_multiport #(.W(16), .D(256), .N(2), .CLEAR(1)) dut (
      .clk(clk), .rst(rst),
      .aw_data(aw_data), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
      .b_valid(b_valid), .b_ready(b_ready),
      .ar_data(ar_data), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready)
   );

   memory_multiport #(.W(16), .D(16), .N(1), .CLEAR(0)) dut_noclr (
      .clk(clk), .rst(e_rst),
      .aw_data(e_aw_data), .aw_valid(e_aw_valid), .aw_ready(e_aw_ready),
      .w_data(e_w_data), .w_strb(e_w_strb), .w_valid(e_w_valid), .w_ready(e_w_ready),
      .b_valid(e_b_valid), .b_ready(e_b_ready),
      .ar_data(e_ar_data), .ar_valid(e_ar_valid), .ar_ready(e_ar_ready),
      .r_data(e_r_data), .r_valid(e_r_valid), .r_ready(e_r_ready)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [15:0] model [256];
   logic [15:0] exp_q [2][$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [15:0] rdat(input int ch);
      return r_data[ch*16 +: 16];
   endfunction

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge after the write handshake.
   task automatic wr(input logic [7:0] addr, input logic [15:0] data, input logic [1:0] strb);
      int n;
      n = 0;
      aw_data  = addr;
      w_data   = data;
      w_strb   = strb;
      aw_valid = 1'b1;
      w_valid  = 1'b1;
      #1;
      while (!(aw_ready && w_ready) && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) check("wr_timeout", 32'd0, 32'd1);
      @(negedge clk);
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      check("wr_b_valid", b_valid, 1'b1);
   endtask

   // Called at a negedge; returns at the negedge after the read data appears.
   task automatic rd(input int ch, input logic [7:0] addr, output logic [15:0] data);
      int n;
      n = 0;
      ar_data[ch*8 +: 8] = addr;
      ar_valid[ch] = 1'b1;
      #1;
      while (!ar_ready[ch] && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) check("rd_timeout", 32'd0, 32'd1);
      @(negedge clk);
      ar_valid[ch] = 1'b0;
      check("rd_r_valid", r_valid[ch], 1'b1);
      data = rdat(ch);
   endtask

   // Release rst and count cycles until ch0 may issue again (sweep length).
   task automatic sweep_count(output int n);
      n = 0;
      rst = 1'b0;
      #1;
      while (!ar_ready[0] && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int issued [2];
      int got [2];
      logic stalled [2];
      logic [15:0] held [2];
      logic [15:0] d;
      logic [7:0] a;

      rst = 1'b1;
      aw_data = '0; aw_valid = 1'b1; w_data = '0; w_strb = '0; w_valid = 1'b1;
      b_ready = 1'b1; ar_data = 16'h0005; ar_valid = 2'b01; r_ready = 2'b11;
      e_rst = 1'b1;
      e_aw_data = '0; e_aw_valid = 1'b0; e_w_data = '0; e_w_strb = '0; e_w_valid = 1'b0;
      e_b_ready = 1'b1; e_ar_data = '0; e_ar_valid = 1'b0; e_r_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_b_valid", b_valid, 1'b0);
      check("rst_r_valid", r_valid, 2'b00);
      check("rst_r_data", r_data, 32'h0);
      check("rst_aw_ready", aw_ready, 1'b0);
      check("rst_w_ready", w_ready, 1'b0);
      check("rst_ar_ready", ar_ready, 2'b00);
      aw_valid = 1'b0;
      w_valid  = 1'b0;

      // CLEAR sweep with ar_valid[0] held at address 5
      sweep_count(n);
      check("sweep_len", n, 256);
      @(negedge clk);
      ar_valid = 2'b00;
      check("sweep_r_valid", r_valid[0], 1'b1);
      check("sweep_rd5", rdat(0), 16'h0000);

      // Strobed write
      wr(8'd3, 16'hABCD, 2'b11);
      wr(8'd3, 16'h1200, 2'b10);
      rd(0, 8'd3, d);
      check("strb_rd3", d, 16'h12CD);
      rd(1, 8'd3, d);
      check("strb_rd3_ch1", d, 16'h12CD);
      wr(8'd4, 16'h7777, 2'b00);
      rd(0, 8'd4, d);
      check("strb_zero", d, 16'h0000);

      // Random fill / readback on both channels with r_ready stalls
      for (int i = 0; i < 256; i++) begin
         model[i] = 16'($urandom_range(0, 65535));
         wr(8'(i), model[i], 2'b11);
      end
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
         issued[ch] = 0; got[ch] = 0; stalled[ch] = 1'b0; held[ch] = '0;
      end
      for (int cyc = 0; cyc < 3000 && (got[0] < 256 || got[1] < 256); cyc++) begin
         @(negedge clk);
         for (int ch = 0; ch < 2; ch++) begin
            if (stalled[ch]) check("fill_stable", rdat(ch), held[ch]);
            stalled[ch] = 1'b0;
            r_ready[ch] = ($urandom_range(0, 3) != 0);
            if (r_valid[ch]) begin
               if (r_ready[ch]) begin
                  if (exp_q[ch].size() == 0) begin
                     check("fill_spurious", 32'd1, 32'd0);
                  end else begin
                     check("fill_rd", rdat(ch), exp_q[ch].pop_front());
                     got[ch]++;
                  end
               end else begin
                  stalled[ch] = 1'b1;
                  held[ch] = rdat(ch);
               end
            end
            ar_valid[ch] = (issued[ch] < 256);
            ar_data[ch*8 +: 8] = (ch == 0) ? 8'(issued[ch]) : 8'(255 - issued[ch]);
         end
         #1;
         for (int ch = 0; ch < 2; ch++) begin
            if (ar_valid[ch] && ar_ready[ch]) begin
               a = ar_data[ch*8 +: 8];
               exp_q[ch].push_back(model[a]);
               issued[ch]++;
            end
         end
      end
      check("fill_count", got[0] + got[1], 512);
      ar_valid = 2'b00;
      r_ready  = 2'b11;
      @(negedge clk);
      @(negedge clk);

      // Write-first forwarding to both channels
      wr(8'd7, 16'hFFFF, 2'b11);
      aw_data = 8'd7; w_data = 16'h5A5A; w_strb = 2'b01;
      aw_valid = 1'b1; w_valid = 1'b1;
      ar_data = {8'd7, 8'd7}; ar_valid = 2'b11;
      #1;
      check("fwd_aw_ready", aw_ready, 1'b1);
      check("fwd_ar_ready", ar_ready, 2'b11);
      @(negedge clk);
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 2'b00;
      check("fwd_r_valid", r_valid, 2'b11);
      check("fwd_ch0", rdat(0), 16'hFF5A);
      check("fwd_ch1", rdat(1), 16'hFF5A);
      check("fwd_b_valid", b_valid, 1'b1);
      @(negedge clk);
      rd(1, 8'd7, d);
      check("fwd_after", d, 16'hFF5A);

      // b backpressure
      b_ready = 1'b0;
      wr(8'd10, 16'h1111, 2'b11);
      aw_data = 8'd11; w_data = 16'h2222; w_strb = 2'b11;
      aw_valid = 1'b1; w_valid = 1'b1;
      #1;
      check("bp_aw_ready", aw_ready, 1'b0);
      check("bp_w_ready", w_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("bp_b_hold", b_valid, 1'b1);
         check("bp_aw_stall", aw_ready, 1'b0);
      end
      b_ready = 1'b1;
      #1;
      check("bp_aw_release", aw_ready, 1'b1);
      check("bp_w_release", w_ready, 1'b1);
      @(negedge clk);
      aw_valid = 1'b0; w_valid = 1'b0;
      check("bp_b_cont", b_valid, 1'b1);
      @(negedge clk);
      check("bp_b_drop", b_valid, 1'b0);
      rd(0, 8'd11, d);
      check("bp_rd11", d, 16'h2222);
      rd(1, 8'd10, d);
      check("bp_rd10", d, 16'h1111);
      @(negedge clk);

      // Reset with b and r beats pending
      b_ready = 1'b0;
      wr(8'd20, 16'h3333, 2'b11);
      r_ready[0] = 1'b0;
      rd(0, 8'd20, d);
      check("pend_rd20", d, 16'h3333);
      rst = 1'b1;
      @(negedge clk);
      check("pend_r_valid", r_valid, 2'b00);
      check("pend_r_data", r_data, 32'h0);
      check("pend_b_valid", b_valid, 1'b0);
      check("pend_ar_ready", ar_ready, 2'b00);
      b_ready = 1'b1;
      r_ready = 2'b11;
      rst = 1'b0;

      // Reset again mid-sweep (around ptr 100); the sweep restarts in full
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      ar_data = 16'h0014;
      ar_valid = 2'b01;
      sweep_count(n);
      check("resweep_len", n, 256);
      @(negedge clk);
      ar_valid = 2'b00;
      check("resweep_rd20", rdat(0), 16'h0000);
      rd(1, 8'd10, d);
      check("resweep_rd10", d, 16'h0000);

      // Instance without sweep: contents persist across reset
      @(negedge clk);
      e_rst = 1'b0;
      #1;
      check("noclr_ar_ready", e_ar_ready, 1'b1);
      @(negedge clk);
      e_aw_data = 4'd4; e_w_data = 16'hBEEF; e_w_strb = 2'b11;
      e_aw_valid = 1'b1; e_w_valid = 1'b1;
      #1;
      check("noclr_aw_ready", e_aw_ready, 1'b1);
      @(negedge clk);
      e_aw_valid = 1'b0; e_w_valid = 1'b0;
      check("noclr_b_valid", e_b_valid, 1'b1);
      e_rst = 1'b1;
      @(negedge clk);
      check("noclr_rst_b", e_b_valid, 1'b0);
      e_rst = 1'b0;
      e_ar_data = 4'd4;
      e_ar_valid = 1'b1;
      #1;
      check("noclr_ar_after", e_ar_ready, 1'b1);
      @(negedge clk);
      e_ar_valid = 1'b0;
      check("noclr_r_valid", e_r_valid, 1'b1);
      check("noclr_persist", e_r_data, 16'hBEEF);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_multiport.md
Name: memory_multiport

Overview:
- Parametrised successor to the single-channel valid/ready memory.
- Adds N independent read channels, byte-lane write strobes and a write-response channel.
- Optional zero-clear sweep after reset.
- Sits behind the core's load/store fabric as shared weight/activation storage; every channel uses the codebase's valid/ready stream handshake.

Parameters:
- W, 16, data width in bits; must be a multiple of 8.
- D, 256, depth in words; must be a power of two, D >= 2.
- N, 2, number of read channels, N >= 1.
- CLEAR, 1, when 1 the array is zeroed by a sweep after reset; when 0 contents persist across reset.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- aw_data  in  A=$clog2(D)  write address.
- aw_valid  in  1  write address valid.
- aw_ready  out  1  write address ready.
- w_data  in  W  write data.
- w_strb  in  W/8  byte-lane enables; bit k enables w_data[8k+7:8k].
- w_valid  in  1  write data valid.
- w_ready  out  1  write data ready.
- b_valid  out  1  write complete.
- b_ready  in  1  write response accepted.
- ar_data  in  N*A  read addresses; channel i uses slice [i*A +: A].
- ar_valid  in  N  per-channel read address valid.
- ar_ready  out  N  per-channel read address ready.
- r_data  out  N*W  read data; channel i uses slice [i*W +: W].
- r_valid  out  N  per-channel read data valid.
- r_ready  in  N  per-channel read data ready.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - b_valid=0, r_valid=0, r_data=0.
  - Clear pointer=0; state=CLEAR if CLEAR=1, else RUN.
  - All readies are 0 while rst=1.
- State CLEAR:
  - Writes zero to address ptr each cycle; ptr increments.
  - On ptr==D-1, the write occurs and state goes to RUN next cycle. Exactly D cycles are spent in CLEAR.
  - aw_ready, w_ready and ar_ready are all 0.
- rst asserted mid-sweep or mid-transaction restarts from the reset state. In-flight b/r beats are discarded; a write accepted on the same edge as rst is not committed.
- Write handshake (RUN):
  - accept = aw_valid & w_valid & (!b_valid | b_ready).
  - aw_ready = w_valid & (!b_valid | b_ready); w_ready = aw_valid & (!b_valid | b_ready). Address and data are always consumed together.
  - On accept: only lanes with w_strb set are updated; all other lanes keep their contents.
  - b_valid=1 the next cycle and holds until b_ready.
  - Back-to-back writes are allowed when b_ready=1: throughput is 1 write/cycle.
  - w_strb=0 still completes with a b beat and no memory change.
- Read channel i (RUN), independent of all other channels:
  - ar_ready[i] = !r_valid[i] | r_ready[i].
  - On ar handshake: r_data[i] is registered next cycle from mem[addr]; r_valid[i]=1.
  - r_data[i] is stable while r_valid[i] & !r_ready[i].
  - Latency 1 cycle; throughput 1 read/cycle per channel under continuous r_ready.
- Same-cycle write and read to the same address is write-first: the read returns merged data (strobed lanes new, other lanes old). Multiple channels reading one address all see the same value.
- Address width A; out-of-range addresses are impossible since D is a power of two.
- No combinational path from any valid to the same channel's ready, except the write pair (aw/w) coupling defined above.

Decomposition:
- Shared package memory_pkg:
  - Function addr_width(D) = $clog2(D).
  - Localparam for lane width 8.
  - enum state_t {CLEAR, RUN}.
- One sub-module memory_read_port: per-channel ar/r handshake and output register. Instanced N times via generate; the array read and forwarding mux live in the parent.

Test Plan:
- CLEAR sweep: CLEAR=1, W=16, D=256; release rst and hold ar_valid[0]=1 at address 5. ar_ready stays 0 for 256 cycles, then the read returns 16'h0000 one cycle after handshake.
- Strobed write: write addr 3 = 16'hABCD with strb 2'b11, then addr 3 = 16'h1200 with strb 2'b10. A read of addr 3 returns 16'h12CD; one b beat per write.
- Full random fill/readback (D=256, W=16, N=2): write every address with random data, then read all addresses on both channels concurrently with random r_ready stalls. All match; each channel holds r_data stable during stalls.
- Write-first forwarding: same cycle, write addr 7 = 16'h5A5A (strb 2'b01, old 16'hFFFF) and read addr 7 on ch0 and ch1. Both return 16'hFF5A.
- b backpressure: b_ready=0 after one write. aw_ready=w_ready=0 until b_ready=1; the second write is accepted on that same cycle and b_valid stays 1 continuously.
- Mid-operation reset: assert rst for 1 cycle during sweep ptr=100, and again with r_valid=1 pending. Outputs return to 0, the sweep restarts and takes 256 cycles. With CLEAR=0, contents written before rst read back unchanged.
